// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Shares the single-port data memory between the pipeline MEM
//               stage and the debug unit, holding each access for WAIT_CYCLES
//               cycles and stalling the pipeline until its data returns.
//               Optional macro ARB_DBG_WRITE_EN adds debug write capability.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int N_BITS      = 32,
    parameter int N_BITS_ADDR = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_memRead,
    input  logic                   i_memWrite,
    input  logic [N_BITS_ADDR-1:0] i_addr_mem,
    input  logic [N_BITS-1:0]      i_wdata_mem,
    output logic [N_BITS-1:0]      o_rdata_mem,
    output logic                   o_stall,
    input  logic                   i_dbg_req,
    input  logic [N_BITS_ADDR-1:0] i_dbg_addr,
`ifdef ARB_DBG_WRITE_EN
    input  logic                   i_dbg_we,
    input  logic [N_BITS-1:0]      i_dbg_wdata,
`endif
    output logic [N_BITS-1:0]      o_dbg_rdata,
    output logic                   o_dbg_ack,
    output logic                   o_mem_en,
    output logic                   o_mem_we,
    output logic [N_BITS_ADDR-1:0] o_mem_addr,
    output logic [N_BITS-1:0]      o_mem_wdata,
    input  logic [N_BITS-1:0]      i_mem_rdata
);

    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    localparam logic OWN_PIPE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state_q,      state_d;
    logic                   owner_q,      owner_d;
    logic                   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       cnt_q,        cnt_d;
    logic                   mem_en_q,     mem_en_d;
    logic                   mem_we_q,     mem_we_d;
    logic [N_BITS_ADDR-1:0] mem_addr_q,   mem_addr_d;
    logic [N_BITS-1:0]      mem_wdata_q,  mem_wdata_d;
    logic [N_BITS-1:0]      rdata_mem_q,  rdata_mem_d;
    logic [N_BITS-1:0]      dbg_rdata_q,  dbg_rdata_d;

    logic              w_pipe_req;
    logic              w_grant_dbg;
    logic              w_done_pipe;
    logic              w_dbg_we;
    logic [N_BITS-1:0] w_dbg_wdata;

`ifdef ARB_DBG_WRITE_EN
    assign w_dbg_we    = i_dbg_we;
    assign w_dbg_wdata = i_dbg_wdata;
`else
    assign w_dbg_we    = 1'b0;
    assign w_dbg_wdata = '0;
`endif

    assign w_pipe_req  = i_valid & (i_memRead | i_memWrite);
    // On a tie the requester that did not win last time is served.
    assign w_grant_dbg = i_dbg_req & (~w_pipe_req | (last_grant_q == OWN_PIPE));
    assign w_done_pipe = (state_q == S_DONE) && (owner_q == OWN_PIPE);

    // Gated by reset so every output reads zero while reset is held.
    assign o_stall     = i_reset & w_pipe_req & ~w_done_pipe;
    assign o_dbg_ack   = (state_q == S_DONE) && (owner_q == OWN_DBG);

    assign o_rdata_mem = rdata_mem_q;
    assign o_dbg_rdata = dbg_rdata_q;
    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_mem_d  = rdata_mem_q;
        dbg_rdata_d  = dbg_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (w_pipe_req | i_dbg_req) begin
                    state_d      = S_ACC;
                    owner_d      = w_grant_dbg;
                    last_grant_d = w_grant_dbg;
                    cnt_d        = '0;
                    mem_en_d     = 1'b1;
                    if (w_grant_dbg) begin
                        mem_addr_d  = i_dbg_addr;
                        mem_wdata_d = w_dbg_wdata;
                        mem_we_d    = w_dbg_we;
                    end else begin
                        mem_addr_d  = i_addr_mem;
                        mem_wdata_d = i_wdata_mem;
                        mem_we_d    = i_memWrite;
                    end
                end
            end
            S_ACC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (owner_q == OWN_DBG) begin
                        dbg_rdata_d = i_mem_rdata;
                    end else begin
                        rdata_mem_d = i_mem_rdata;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_PIPE;
            last_grant_q <= OWN_DBG;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_mem_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_mem_q  <= rdata_mem_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Directed bench for data_mem_arbiter (WAIT_CYCLES=2); the
//               ARB_DBG_WRITE_EN section runs only when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        valid, mem_read, mem_write;
    logic [9:0]  addr_mem;
    logic [31:0] wdata_mem;
    logic [31:0] rdata_mem;
    logic        stall;
    logic        dbg_req;
    logic [9:0]  dbg_addr;
`ifdef ARB_DBG_WRITE_EN
    logic        dbg_we;
    logic [31:0] dbg_wdata;
`endif
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    data_mem_arbiter #(
        .N_BITS      (32),
        .N_BITS_ADDR (10),
        .WAIT_CYCLES (2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_valid     (valid),
        .i_memRead   (mem_read),
        .i_memWrite  (mem_write),
        .i_addr_mem  (addr_mem),
        .i_wdata_mem (wdata_mem),
        .o_rdata_mem (rdata_mem),
        .o_stall     (stall),
        .i_dbg_req   (dbg_req),
        .i_dbg_addr  (dbg_addr),
`ifdef ARB_DBG_WRITE_EN
        .i_dbg_we    (dbg_we),
        .i_dbg_wdata (dbg_wdata),
`endif
        .o_dbg_rdata (dbg_rdata),
        .o_dbg_ack   (dbg_ack),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr_mem = '0; wdata_mem = '0; dbg_req = 1'b0; dbg_addr = '0; mem_rdata = '0;
`ifdef ARB_DBG_WRITE_EN
        dbg_we = 1'b0; dbg_wdata = '0;
`endif
        #2 rst_n = 1'b0;

        // Reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            addr_mem = 10'($urandom); wdata_mem = $urandom; dbg_req = 1'($urandom);
            dbg_addr = 10'($urandom); mem_rdata = $urandom;
            smp();
            check("rst_en", 32'(mem_en), 32'd0);
            check("rst_we", 32'(mem_we), 32'd0);
            check("rst_addr", 32'(mem_addr), 32'd0);
            check("rst_wdata", mem_wdata, 32'd0);
            check("rst_rdata_mem", rdata_mem, 32'd0);
            check("rst_dbg_rdata", dbg_rdata, 32'd0);
            check("rst_ack", 32'(dbg_ack), 32'd0);
            check("rst_stall", 32'(stall), 32'd0);
            cyc();
        end
        valid = 0; mem_read = 0; mem_write = 0; addr_mem = '0; wdata_mem = '0;
        dbg_req = 0; dbg_addr = '0; mem_rdata = '0;
        rst_n = 1'b1;
        smp();
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_en", 32'(mem_en), 32'd0);
        cyc();

        // Pipeline read
        valid = 1; mem_read = 1; addr_mem = 10'h010; mem_rdata = 32'hDEADBEEF;
        smp(); check("rd_c0_stall", 32'(stall), 32'd1); check("rd_c0_en", 32'(mem_en), 32'd0); cyc();
        smp(); check("rd_c1_en", 32'(mem_en), 32'd1); check("rd_c1_addr", 32'(mem_addr), 32'h010);
        check("rd_c1_we", 32'(mem_we), 32'd0); check("rd_c1_stall", 32'(stall), 32'd1); cyc();
        smp(); check("rd_c2_en", 32'(mem_en), 32'd1); check("rd_c2_stall", 32'(stall), 32'd1); cyc();
        smp(); check("rd_c3_stall", 32'(stall), 32'd0); check("rd_c3_data", rdata_mem, 32'hDEADBEEF);
        check("rd_c3_en", 32'(mem_en), 32'd0); cyc();
        mem_read = 0;

        // Pipeline write
        mem_write = 1; addr_mem = 10'h004; wdata_mem = 32'h12345678;
        smp(); check("wr_c0_stall", 32'(stall), 32'd1); cyc();
        smp(); check("wr_c1_we", 32'(mem_we), 32'd1); check("wr_c1_en", 32'(mem_en), 32'd1);
        check("wr_c1_addr", 32'(mem_addr), 32'h004); check("wr_c1_wdata", mem_wdata, 32'h12345678); cyc();
        smp(); check("wr_c2_we", 32'(mem_we), 32'd1); check("wr_c2_stall", 32'(stall), 32'd1); cyc();
        smp(); check("wr_c3_stall", 32'(stall), 32'd0); check("wr_c3_we", 32'(mem_we), 32'd0);
        check("wr_c3_en", 32'(mem_en), 32'd0); cyc();

        // Read and write together is a write
        mem_read = 1; mem_write = 1; addr_mem = 10'h0AA; wdata_mem = 32'h0BADF00D;
        cyc();
        smp(); check("rw_c1_we", 32'(mem_we), 32'd1); check("rw_c1_wdata", mem_wdata, 32'h0BADF00D); cyc();
        cyc();
        smp(); check("rw_c3_stall", 32'(stall), 32'd0); cyc();
        mem_read = 0; mem_write = 0;

        // i_valid drops mid-access; result still captured and held
        valid = 1; mem_read = 1; addr_mem = 10'h100; mem_rdata = 32'h5A5A0001;
        cyc();
        valid = 0;
        smp(); check("vd_c1_en", 32'(mem_en), 32'd1); check("vd_c1_stall", 32'(stall), 32'd0); cyc();
        cyc();
        smp(); check("vd_c3_data", rdata_mem, 32'h5A5A0001); check("vd_c3_en", 32'(mem_en), 32'd0); cyc();
        mem_read = 0; mem_rdata = 32'h0;
        smp(); check("vd_hold", rdata_mem, 32'h5A5A0001); cyc();

        // Reset in the middle of a debug access
        valid = 1; dbg_req = 1; dbg_addr = 10'h055;
        smp(); check("mr_c0_stall", 32'(stall), 32'd0); check("mr_c0_ack", 32'(dbg_ack), 32'd0); cyc();
        smp(); check("mr_c1_en", 32'(mem_en), 32'd1); check("mr_c1_addr", 32'(mem_addr), 32'h055); cyc();
        rst_n = 1'b0;
        #1;
        check("mr_rst_en", 32'(mem_en), 32'd0); check("mr_rst_ack", 32'(dbg_ack), 32'd0);
        smp(); cyc();
        smp(); check("mr_rst_ack2", 32'(dbg_ack), 32'd0); cyc();
        rst_n = 1'b1; dbg_addr = 10'h066; mem_rdata = 32'hCAFEF00D;
        smp(); check("mr_n0_ack", 32'(dbg_ack), 32'd0); check("mr_n0_en", 32'(mem_en), 32'd0); cyc();
        smp(); check("mr_n1_en", 32'(mem_en), 32'd1); check("mr_n1_addr", 32'(mem_addr), 32'h066);
        check("mr_n1_we", 32'(mem_we), 32'd0); cyc();
        smp(); check("mr_n2_ack", 32'(dbg_ack), 32'd0); cyc();
        smp(); check("mr_n3_ack", 32'(dbg_ack), 32'd1); check("mr_n3_data", dbg_rdata, 32'hCAFEF00D);
        check("mr_n3_en", 32'(mem_en), 32'd0); cyc();
        dbg_req = 0;
        smp(); check("mr_n4_ack", 32'(dbg_ack), 32'd0); check("mr_n4_hold", dbg_rdata, 32'hCAFEF00D); cyc();

        // Conflict after reset: pipe first, then round-robin gives debug the next tie
        rst_n = 1'b0; #1; rst_n = 1'b1;
        valid = 1; mem_read = 1; addr_mem = 10'h011; dbg_req = 1; dbg_addr = 10'h020;
        mem_rdata = 32'h11111111;
        smp(); check("cf_c0_stall", 32'(stall), 32'd1); cyc();
        smp(); check("cf_c1_addr", 32'(mem_addr), 32'h011); check("cf_c1_en", 32'(mem_en), 32'd1); cyc();
        cyc();
        smp(); check("cf_c3_stall", 32'(stall), 32'd0); check("cf_c3_data", rdata_mem, 32'h11111111);
        check("cf_c3_ack", 32'(dbg_ack), 32'd0); cyc();
        addr_mem = 10'h012; mem_rdata = 32'h22222222;
        smp(); check("cf_c4_en", 32'(mem_en), 32'd0); check("cf_c4_stall", 32'(stall), 32'd1); cyc();
        smp(); check("cf_c5_en", 32'(mem_en), 32'd1); check("cf_c5_addr", 32'(mem_addr), 32'h020); cyc();
        smp(); check("cf_c6_ack", 32'(dbg_ack), 32'd0); cyc();
        smp(); check("cf_c7_ack", 32'(dbg_ack), 32'd1); check("cf_c7_data", dbg_rdata, 32'h22222222);
        check("cf_c7_stall", 32'(stall), 32'd1); check("cf_c7_pipe_hold", rdata_mem, 32'h11111111); cyc();
        dbg_req = 0; mem_rdata = 32'h33333333;
        smp(); check("cf_c8_en", 32'(mem_en), 32'd0); check("cf_c8_stall", 32'(stall), 32'd1); cyc();
        smp(); check("cf_c9_en", 32'(mem_en), 32'd1); check("cf_c9_addr", 32'(mem_addr), 32'h012); cyc();
        smp(); check("cf_c10_stall", 32'(stall), 32'd1); cyc();
        smp(); check("cf_c11_stall", 32'(stall), 32'd0); check("cf_c11_data", rdata_mem, 32'h33333333); cyc();
        valid = 0; mem_read = 0;

`ifdef ARB_DBG_WRITE_EN
        // Debug write, then debug read of the same word
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h3FF; dbg_wdata = 32'hA5A5A5A5;
        cyc();
        smp(); check("dw_c1_we", 32'(mem_we), 32'd1); check("dw_c1_addr", 32'(mem_addr), 32'h3FF);
        check("dw_c1_wdata", mem_wdata, 32'hA5A5A5A5); cyc();
        smp(); check("dw_c2_we", 32'(mem_we), 32'd1); cyc();
        smp(); check("dw_c3_ack", 32'(dbg_ack), 32'd1); check("dw_c3_we", 32'(mem_we), 32'd0); cyc();
        dbg_we = 0; mem_rdata = 32'hA5A5A5A5;
        cyc();
        smp(); check("dr_c1_we", 32'(mem_we), 32'd0); cyc();
        cyc();
        smp(); check("dr_c3_ack", 32'(dbg_ack), 32'd1); check("dr_c3_data", dbg_rdata, 32'hA5A5A5A5); cyc();
        dbg_req = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
